rom_word_loader: RTL and testbench

ROM_WORD_LOADER -- requirements
Module: rom_word_loader

---
 rtl/rom_word_loader.sv | 115 +++++++++++
 tb/tb_rom_word_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_word_loader.sv
// Streams source words into a ROM while a load session is active.
// Optional running checksum of written words: define ROM_WORD_LOADER_CHECKSUM_EN.
module rom_word_loader #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ROM_DEPTH  = 32768,
  localparam int ADDR_WIDTH = $clog2(ROM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rom_loader_load,
  input  logic [DATA_WIDTH-1:0] rom_loader_data,
  input  logic                  rom_loader_sck,
  output logic                  rom_loader_ack,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] rom_wdata,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(ROM_DEPTH);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, cnt_base;
  logic                  ovf_q, ovf_d, ovf_base;
  logic                  entry, accept, full;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rom_loader_load) state_d = LOAD;
      LOAD:    if (!rom_loader_load) state_d = DONE;
      DONE:    if (rom_loader_load) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Session entry clears the statistics in the same cycle, so a word
  // offered on the entry edge already sees a zero count.
  always_comb begin
    entry    = rom_loader_load && (state_q != LOAD);
    accept   = rom_loader_load && rom_loader_sck;
    cnt_base = entry ? '0 : cnt_q;
    ovf_base = entry ? 1'b0 : ovf_q;
    full     = (cnt_base == DEPTH_C);

    we_d    = accept && !full;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_base;
    ovf_d   = ovf_base;
    if (we_d) begin
      addr_d  = cnt_base[ADDR_WIDTH-1:0];
      wdata_d = rom_loader_data;
      cnt_d   = cnt_base + 1'b1;
    end
    if (accept && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef ROM_WORD_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cs_q, cs_d;

  always_comb begin
    cs_d = entry ? '0 : cs_q;
    if (we_d) cs_d = cs_d + rom_loader_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cs_q <= '0;
    else       cs_q <= cs_d;
  end

  assign checksum = cs_q;
`else
  assign checksum = '0;
`endif

  assign rom_we         = we_q;
  assign rom_loader_ack = we_q;
  assign rom_addr       = addr_q;
  assign rom_wdata      = wdata_q;
  assign busy           = (state_q == LOAD);
  assign word_count     = cnt_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_rom_word_loader.sv
// Scoreboard bench: stimulus pushes expected writes/status, one monitor compares.
module tb_rom_word_loader;

`ifdef ROM_WORD_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        load = 1'b0, sck = 1'b0;
  logic [15:0] data = '0;
  logic        m_ack, m_we, m_busy, m_ovf;
  logic [14:0] m_addr;
  logic [15:0] m_wdata, m_cs;
  logic [15:0] m_cnt;

  logic        load4 = 1'b0, sck4 = 1'b0;
  logic [15:0] data4 = '0;
  logic        f_ack, f_we, f_busy, f_ovf;
  logic [1:0]  f_addr;
  logic [15:0] f_wdata, f_cs;
  logic [2:0]  f_cnt;

  always #5 clk = ~clk;

  rom_word_loader dut (
    .clk(clk), .reset(reset),
    .rom_loader_load(load), .rom_loader_data(data), .rom_loader_sck(sck),
    .rom_loader_ack(m_ack), .rom_we(m_we), .rom_addr(m_addr), .rom_wdata(m_wdata),
    .busy(m_busy), .word_count(m_cnt), .overflow(m_ovf), .checksum(m_cs)
  );

  rom_word_loader #(.DATA_WIDTH(16), .ROM_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .rom_loader_load(load4), .rom_loader_data(data4), .rom_loader_sck(sck4),
    .rom_loader_ack(f_ack), .rom_we(f_we), .rom_addr(f_addr), .rom_wdata(f_wdata),
    .busy(f_busy), .word_count(f_cnt), .overflow(f_ovf), .checksum(f_cs)
  );

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    string       tag;
    bit          sel;
    bit          bus;
    logic        busy;
    logic [15:0] cnt;
    logic        ovf;
    logic [15:0] cs;
  } st_t;

  wr_t q_main[$];
  wr_t q_four[$];
  st_t q_st[$];
  int  passed = 0;
  int  total  = 0;
  bit  done   = 1'b0;

  function automatic logic [15:0] cs(input logic [15:0] v);
    return CS_EN ? v : 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic exp_wr(input bit sel, input logic [14:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    if (sel) q_four.push_back(w);
    else     q_main.push_back(w);
  endtask

  task automatic exp_st(input string tag, input bit sel, input bit bus, input logic busy_e,
                        input logic [15:0] cnt_e, input logic ovf_e, input logic [15:0] cs_e);
    st_t s;
    s.tag = tag; s.sel = sel; s.bus = bus; s.busy = busy_e;
    s.cnt = cnt_e; s.ovf = ovf_e; s.cs = cs_e;
    q_st.push_back(s);
  endtask

  task automatic cyc(input logic l, input logic s, input logic [15:0] d);
    load = l; sck = s; data = d;
    @(posedge clk); #1;
  endtask

  task automatic cyc4(input logic l, input logic s, input logic [15:0] d);
    load4 = l; sck4 = s; data4 = d;
    @(posedge clk); #1;
  endtask

  // Single checking process: write scoreboards, ack/we agreement, status snapshots.
  always @(negedge clk) begin
    wr_t w;
    st_t s;
    if (m_we) begin
      if (q_main.size() == 0) chk("main_unexpected_write", {17'b0, m_addr}, 32'hFFFF_FFFF);
      else begin
        w = q_main.pop_front();
        chk("main_addr", {17'b0, m_addr}, {17'b0, w.addr});
        chk("main_wdata", {16'b0, m_wdata}, {16'b0, w.data});
      end
    end
    chk("main_ack_eq_we", {31'b0, m_ack}, {31'b0, m_we});
    if (f_we) begin
      if (q_four.size() == 0) chk("d4_unexpected_write", {30'b0, f_addr}, 32'hFFFF_FFFF);
      else begin
        w = q_four.pop_front();
        chk("d4_addr", {30'b0, f_addr}, {17'b0, w.addr});
        chk("d4_wdata", {16'b0, f_wdata}, {16'b0, w.data});
      end
    end
    chk("d4_ack_eq_we", {31'b0, f_ack}, {31'b0, f_we});
    while (q_st.size() > 0) begin
      s = q_st.pop_front();
      if (!s.sel) begin
        chk({s.tag, "_busy"}, {31'b0, m_busy}, {31'b0, s.busy});
        chk({s.tag, "_count"}, {16'b0, m_cnt}, {16'b0, s.cnt});
        chk({s.tag, "_ovf"}, {31'b0, m_ovf}, {31'b0, s.ovf});
        chk({s.tag, "_cs"}, {16'b0, m_cs}, {16'b0, s.cs});
        if (s.bus) begin
          chk({s.tag, "_we"}, {31'b0, m_we}, 32'h0);
          chk({s.tag, "_ack"}, {31'b0, m_ack}, 32'h0);
          chk({s.tag, "_addr"}, {17'b0, m_addr}, 32'h0);
          chk({s.tag, "_wdata"}, {16'b0, m_wdata}, 32'h0);
        end
      end else begin
        chk({s.tag, "_busy"}, {31'b0, f_busy}, {31'b0, s.busy});
        chk({s.tag, "_count"}, {29'b0, f_cnt}, {16'b0, s.cnt});
        chk({s.tag, "_ovf"}, {31'b0, f_ovf}, {31'b0, s.ovf});
        chk({s.tag, "_cs"}, {16'b0, f_cs}, {16'b0, s.cs});
      end
    end
    if (done) begin
      chk("main_pending_writes", q_main.size(), 32'd0);
      chk("d4_pending_writes", q_four.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

  initial begin
    exp_st("reset", 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'h0);
    exp_st("reset4", 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'h0);
    @(negedge clk); #1;
    reset = 1'b0;

    // Four back-to-back words
    exp_wr(0, 15'd0, 16'h0000);
    exp_wr(0, 15'd1, 16'hEA87);
    exp_wr(0, 15'd2, 16'hFFFF);
    exp_wr(0, 15'd3, 16'h0000);
    cyc(1, 1, 16'h0000);
    exp_st("t1_first", 0, 0, 1'b1, 16'd1, 1'b0, cs(16'h0000));
    cyc(1, 1, 16'hEA87);
    cyc(1, 1, 16'hFFFF);
    cyc(1, 1, 16'h0000);
    exp_st("t1_last", 0, 0, 1'b1, 16'd4, 1'b0, cs(16'hEA86));
    cyc(0, 0, 16'h0000);
    exp_st("t1_done", 0, 0, 1'b0, 16'd4, 1'b0, cs(16'hEA86));

    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 16'h0000);
      exp_st("t2_hold", 0, 0, 1'b0, 16'd4, 1'b0, cs(16'hEA86));
    end

    // New session, strobe pattern 1,0,1,0,1
    exp_wr(0, 15'd0, 16'h1111);
    exp_wr(0, 15'd1, 16'h2222);
    exp_wr(0, 15'd2, 16'h3333);
    cyc(1, 1, 16'h1111);
    exp_st("t3_restart", 0, 0, 1'b1, 16'd1, 1'b0, cs(16'h1111));
    cyc(1, 0, 16'hDEAD);
    cyc(1, 1, 16'h2222);
    cyc(1, 0, 16'hBEEF);
    cyc(1, 1, 16'h3333);
    exp_st("t3_last", 0, 0, 1'b1, 16'd3, 1'b0, cs(16'h6666));
    cyc(0, 0, 16'h0000);
    exp_st("t3_done", 0, 0, 1'b0, 16'd3, 1'b0, cs(16'h6666));

    // Asynchronous reset after two writes
    exp_wr(0, 15'd0, 16'hAAAA);
    exp_wr(0, 15'd1, 16'h5555);
    cyc(1, 1, 16'hAAAA);
    cyc(1, 1, 16'h5555);
    cyc(1, 0, 16'h0000);
    #2 reset = 1'b1;
    exp_st("t4_async_rst", 0, 1, 1'b0, 16'd0, 1'b0, 16'h0);
    @(negedge clk); #1;
    reset = 1'b0;

    // First edge after reset accepts at address 0; checksum wrap
    exp_wr(0, 15'd0, 16'hFFFF);
    exp_wr(0, 15'd1, 16'h0002);
    cyc(1, 1, 16'hFFFF);
    cyc(1, 1, 16'h0002);
    cyc(0, 0, 16'h0000);
    exp_st("t5_cs", 0, 0, 1'b0, 16'd2, 1'b0, cs(16'h0001));

    // Depth-4 instance: six words offered
    for (int i = 1; i <= 4; i++) exp_wr(1, 15'(i - 1), 16'(i));
    for (int i = 1; i <= 6; i++) begin
      cyc4(1, 1, 16'(i));
      if (i == 4) exp_st("t6_full", 1, 0, 1'b1, 16'd4, 1'b0, cs(16'h000A));
      if (i == 5) exp_st("t6_ovf5", 1, 0, 1'b1, 16'd4, 1'b1, cs(16'h000A));
      if (i == 6) exp_st("t6_ovf6", 1, 0, 1'b1, 16'd4, 1'b1, cs(16'h000A));
    end
    cyc4(0, 0, 16'h0000);
    exp_st("t6_done", 1, 0, 1'b0, 16'd4, 1'b1, cs(16'h000A));
    cyc4(0, 0, 16'h0000);
    cyc4(0, 0, 16'h0000);

    done = 1'b1;
    #100;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1);
  end

endmodule
